alu_mul_seq: RTL and testbench

Multi-cycle unsigned multiply sequencer that reuses the shared execute-stage ALU instead of adding a hardware multiplier. It uses shift-and-add, one multiplier bit per cycle. It drives the ALU's ifun/aluA/aluB inputs and captures valE. It sits beside the execute stage, is started by a one-cycle request, and returns the low WIDTH bits of the product plus condition codes in the same 3-bit layout the ALU produces.

---
 rtl/alu_mul_seq_pkg.sv | 28 ++
 rtl/alu.sv | 20 ++
 rtl/alu_mul_seq.sv | 105 ++++++++++
 tb/tb_alu_mul_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier: word/ALU-function defines and FSM state type.
// The optional macro MUL_EARLY_EXIT_EN is consumed by alu_mul_seq.sv.
`ifndef WORD
`define WORD 63:0
`endif
`ifndef IFUNBUS
`define IFUNBUS 3:0
`endif
`ifndef ALUADD
`define ALUADD 4'h0
`endif
`ifndef MUL_IDLE
`define MUL_IDLE 2'd0
`define MUL_RUN  2'd1
`define MUL_DONE 2'd2
`endif

package alu_mul_seq_pkg;

   typedef enum logic [1:0] {
      MulIdle = `MUL_IDLE,
      MulRun  = `MUL_RUN,
      MulDone = `MUL_DONE
   } mul_state_e;

   localparam logic [`IFUNBUS] AluFunAdd = `ALUADD;

endpackage

// File: rtl/alu.sv
// Shared execute-stage ALU: valE = aluB OP aluA, selected by ifun.
module alu (
   input  logic [`IFUNBUS] ifun_i,
   input  logic [`WORD]    a_i,
   input  logic [`WORD]    b_i,
   output logic [`WORD]    val_e_o
);

   always_comb begin
      val_e_o = '0;
      unique case (ifun_i)
         4'h0:    val_e_o = b_i + a_i;
         4'h1:    val_e_o = b_i - a_i;
         4'h2:    val_e_o = b_i & a_i;
         4'h3:    val_e_o = b_i ^ a_i;
         default: val_e_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU adder, one multiplier bit per cycle.
// Define MUL_EARLY_EXIT_EN to leave RUN once no set multiplier bits remain.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       cc,
   output logic [`IFUNBUS]  alu_ifun,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_valE
);

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       cc_q, cc_d;
   logic [WIDTH-1:0] acc_next;
   logic             last_run;

   // The ALU always sees mcand + acc; the sum is only kept when the current multiplier bit is set.
   assign acc_next = mplr_q[0] ? alu_valE : acc_q;

`ifdef MUL_EARLY_EXIT_EN
   assign last_run = (cnt_q == CNT_W'(WIDTH - 1)) || (mplr_q[WIDTH-1:1] == '0);
`else
   assign last_run = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cc_d     = cc_q;
      unique case (state_q)
         MulIdle: begin
            if (start) begin
               mcand_d = op_a;
               mplr_d  = op_b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MulRun;
            end
         end
         MulRun: begin
            acc_d   = acc_next;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (last_run) begin
               result_d = acc_next;
               cc_d     = {(acc_next == '0), acc_next[WIDTH-1], 1'b0};
               state_d  = MulDone;
            end
         end
         MulDone: state_d = MulIdle;
         default: state_d = MulIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= MulIdle;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         cc_q     <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cc_q     <= cc_d;
      end
   end

   assign busy     = (state_q != MulIdle);
   assign done     = (state_q == MulDone);
   assign result   = result_q;
   assign cc       = cc_q;
   assign alu_ifun = AluFunAdd;
   assign alu_a    = mcand_q;
   assign alu_b    = acc_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq wired to the shared ALU; honours MUL_EARLY_EXIT_EN.
module tb_alu_mul_seq;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          busy, done;
   logic [W-1:0]  result;
   logic [2:0]    cc;
   logic [3:0]    alu_ifun;
   logic [W-1:0]  alu_a, alu_b, alu_valE;

   typedef struct {
      logic [W-1:0] res;
      logic [2:0]   cc;
      int           runs;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_mul_seq #(.WIDTH(W), .CNT_W(7)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cc       (cc),
      .alu_ifun (alu_ifun),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_valE (alu_valE)
   );

   alu u_alu (
      .ifun_i  (alu_ifun),
      .a_i     (alu_a),
      .b_i     (alu_b),
      .val_e_o (alu_valE)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: full-precision product truncated to W bits; RUN length from the multiplier's top bit.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.res = p[W-1:0];
      e.cc  = {(e.res == 0), e.res[W-1], 1'b0};
`ifdef MUL_EARLY_EXIT_EN
      e.runs = 1;
      for (int i = 0; i < W; i++) if (b[i]) e.runs = i + 1;
`else
      e.runs = W;
`endif
      return e;
   endfunction

   // Monitor: busy run length and result/cc are compared when done appears.
   initial begin
      int   busy_len;
      exp_t e;
      busy_len = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !busy) busy_len = 0;
         else busy_len++;
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
               e = sb.pop_front();
               chk("done_result", result, e.res);
               chk("done_cc", {61'd0, cc}, {61'd0, e.cc});
               chk("busy_cycles", 64'(busy_len), 64'(e.runs + 1));
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_accept);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      if (expect_accept) sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = {$urandom, $urandom};
      op_b  = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
   endtask

   task automatic run_and_hold(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e = model(a, b);
      issue(a, b, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("held_result", result, e.res);
      chk("held_cc", {61'd0, cc}, {61'd0, e.cc});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   ign_delay;
      int   rst_delay;
`ifdef MUL_EARLY_EXIT_EN
      ign_delay = 1;
      rst_delay = 1;
`else
      ign_delay = 10;
      rst_delay = 20;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_cc", {61'd0, cc}, 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("alu_ifun_add", {60'd0, alu_ifun}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_and_hold(64'd3, 64'd5);
      run_and_hold(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      run_and_hold(64'd0, 64'd12345);
      run_and_hold(64'd9, 64'd1);
      run_and_hold(64'd1, 64'h8000_0000_0000_0000);
      run_and_hold(64'd5, 64'd0);

      // Second request while running must be dropped.
      issue(64'd7, 64'd6, 1'b1);
      repeat (ign_delay) @(posedge clk);
      issue(64'd9, 64'd9, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("ignored_start_result", result, 64'd42);

      // Mid-run reset aborts without a done pulse.
      issue(64'd7, 64'd6, 1'b1);
      repeat (rst_delay) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_result", result, 64'd0);
      chk("abort_cc", {61'd0, cc}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      run_and_hold(64'd7, 64'd6);

      for (int n = 0; n < 30; n++) begin
         logic [W-1:0] a, b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (n % 3 == 1) b = b >> $urandom_range(63, 1);
         if (n % 5 == 2) a = a >> $urandom_range(63, 1);
         run_and_hold(a, b);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
